// File: rtl/dmem_arbiter.sv
// Data memory arbiter: shares the single-ported data memory between the MEM stage
// and a DMA/loader port. The CPU has priority; the DMA gets in when the CPU is idle or starved.
module dmem_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned MAX_BURST    = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              cpu_memread,
  input  logic              cpu_memwrite,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam int unsigned BW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);

  typedef enum logic {
    S_CPU = 1'b0,
    S_DMA = 1'b1
  } owner_e;

  owner_e            owner_q, owner_d;
  logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
  logic [BW-1:0]     burst_cnt_q, burst_cnt_d;
  logic              dma_rvalid_q;
  logic [DATA_W-1:0] dma_rdata_q;

  logic cpu_req;
  logic starve_hit;
  logic burst_hit;

  assign cpu_req    = cpu_memread | cpu_memwrite;
  assign starve_hit = (starve_cnt_q == SW'(STARVE_LIMIT - 1));
  assign burst_hit  = (burst_cnt_q == BW'(MAX_BURST - 1));

  // Ownership and fairness counters
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      owner_q      <= S_CPU;
      starve_cnt_q <= '0;
      burst_cnt_q  <= '0;
    end else begin
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

  // Next owner: starvation forces DMA in, the burst cap hands the memory back to a waiting CPU
  always_comb begin
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;
    burst_cnt_d  = burst_cnt_q;
    case (owner_q)
      S_CPU: begin
        if (!dma_req) begin
          starve_cnt_d = '0;
        end else if (!cpu_req || starve_hit) begin
          owner_d      = S_DMA;
          starve_cnt_d = '0;
          burst_cnt_d  = '0;
        end else begin
          starve_cnt_d = starve_cnt_q + SW'(1);
        end
      end
      S_DMA: begin
        if (!dma_req) begin
          owner_d = S_CPU;
        end else if (cpu_req) begin
          if (burst_hit) begin
            owner_d = S_CPU;
          end else begin
            burst_cnt_d = burst_cnt_q + BW'(1);
          end
        end
      end
      default: owner_d = S_CPU;
    endcase
  end

  // Memory port mux; strobes are masked while reset is held
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_write = cpu_memwrite;
    mem_read  = cpu_memread;
    cpu_rdata = mem_rdata;
    cpu_stall = 1'b0;
    dma_ack   = 1'b0;
    if (owner_q == S_DMA) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_write = dma_req & dma_we;
      mem_read  = dma_req & ~dma_we;
      cpu_rdata = '0;
      cpu_stall = cpu_req;
      dma_ack   = dma_req;
    end
    if (RESET) begin
      mem_write = 1'b0;
      mem_read  = 1'b0;
      cpu_stall = 1'b0;
      dma_ack   = 1'b0;
    end
  end

  // DMA read return, valid one cycle after the read ack
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      dma_rvalid_q <= 1'b0;
      dma_rdata_q  <= '0;
    end else if (dma_ack && !dma_we) begin
      dma_rvalid_q <= 1'b1;
      dma_rdata_q  <= mem_rdata;
    end else begin
      dma_rvalid_q <= 1'b0;
    end
  end

  assign dma_rvalid = dma_rvalid_q;
  assign dma_rdata  = dma_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by random traffic, all checked
// against a cycle-level arbitration model and a reference copy of memory.
module tb_dmem_arbiter;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int          SLIM  = 4;
  localparam int          MBUR  = 4;

  logic          CLK, RESET;
  logic          cpu_memread, cpu_memwrite;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic          dma_req, dma_we, dma_ack, dma_rvalid;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_write, mem_read;

  dmem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SLIM), .MAX_BURST(MBUR)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .cpu_memread(cpu_memread), .cpu_memwrite(cpu_memwrite),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  // Data memory: combinational read, write on the clock edge
  logic [DW-1:0] tb_mem  [0:63];
  logic [DW-1:0] ref_mem [0:63];
  assign mem_rdata = tb_mem[mem_addr[7:2]];
  always @(posedge CLK) if (mem_write) tb_mem[mem_addr[7:2]] <= mem_wdata;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Arbitration model state
  bit            m_dma_owns;
  int            m_wait, m_run;
  bit            m_rvalid;
  logic [DW-1:0] m_rdata;
  bit            e_ack, e_stall;
  logic          obs_ack, obs_stall, obs_rvalid;
  logic [DW-1:0] obs_rdata, obs_dma_rdata;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cpu(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    cpu_memread = r; cpu_memwrite = w; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_dma(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    dma_req = r; dma_we = w; dma_addr = a; dma_wdata = d;
  endtask

  task automatic model_reset();
    m_dma_owns = 1'b0; m_wait = 0; m_run = 0; m_rvalid = 1'b0; m_rdata = '0;
    e_ack = 1'b0; e_stall = 1'b0;
  endtask

  // Called at posedge+1 with inputs driven; checks this cycle and advances to next posedge+1
  task automatic run_cycle();
    bit creq, ewr, erd;
    #1;
    creq    = cpu_memread | cpu_memwrite;
    e_ack   = m_dma_owns && dma_req;
    e_stall = m_dma_owns && creq;
    ewr     = m_dma_owns ? (dma_req && dma_we) : cpu_memwrite;
    erd     = m_dma_owns ? (dma_req && !dma_we) : cpu_memread;
    obs_ack = dma_ack; obs_stall = cpu_stall; obs_rvalid = dma_rvalid;
    obs_rdata = cpu_rdata; obs_dma_rdata = dma_rdata;
    chk1("dma_ack", dma_ack, e_ack);
    chk1("cpu_stall", cpu_stall, e_stall);
    chk1("mem_write", mem_write, ewr);
    chk1("mem_read", mem_read, erd);
    chk32("mem_addr", mem_addr, m_dma_owns ? dma_addr : cpu_addr);
    if (ewr) chk32("mem_wdata", mem_wdata, m_dma_owns ? dma_wdata : cpu_wdata);
    chk32("cpu_rdata", cpu_rdata, m_dma_owns ? 32'h0 : ref_mem[cpu_addr[7:2]]);
    chk1("dma_rvalid", dma_rvalid, m_rvalid);
    chk32("dma_rdata", dma_rdata, m_rdata);
    // effects of the access the model says happened
    if (!m_dma_owns && cpu_memwrite) ref_mem[cpu_addr[7:2]] = cpu_wdata;
    if (e_ack && dma_we) ref_mem[dma_addr[7:2]] = dma_wdata;
    if (e_ack && !dma_we) begin
      m_rvalid = 1'b1;
      m_rdata  = ref_mem[dma_addr[7:2]];
    end else begin
      m_rvalid = 1'b0;
    end
    // ownership rules: m_wait = denied DMA cycles, m_run = capped DMA cycles served
    if (!m_dma_owns) begin
      if (dma_req && (!creq || m_wait == SLIM - 1)) begin
        m_dma_owns = 1'b1; m_wait = 0; m_run = 0;
      end else if (dma_req) begin
        m_wait = m_wait + 1;
      end else begin
        m_wait = 0;
      end
    end else begin
      if (!dma_req) m_dma_owns = 1'b0;
      else if (creq && m_run == MBUR - 1) m_dma_owns = 1'b0;
      else if (creq) m_run = m_run + 1;
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int lat, first, k, run, maxrun, acks, stalls;
    for (int i = 0; i < 64; i++) begin
      tb_mem[i]  = 32'(i) * 32'h0101;
      ref_mem[i] = 32'(i) * 32'h0101;
    end

    // Reset state with requests present on both sides
    RESET = 1'b1;
    set_cpu(1'b0, 1'b1, 32'h4, 32'h1234);
    set_dma(1'b1, 1'b1, 32'h8, 32'h5678);
    #3;
    chk1("rst_cpu_stall", cpu_stall, 1'b0);
    chk1("rst_dma_ack", dma_ack, 1'b0);
    chk1("rst_mem_write", mem_write, 1'b0);
    chk1("rst_mem_read", mem_read, 1'b0);
    chk1("rst_dma_rvalid", dma_rvalid, 1'b0);
    chk32("rst_dma_rdata", dma_rdata, 32'h0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    set_dma(1'b0, 1'b0, 32'h0, 32'h0);
    model_reset();

    // CPU only: sw then lw at address 4
    stalls = 0;
    set_cpu(1'b0, 1'b1, 32'h4, 32'd40);
    run_cycle(); stalls += int'(obs_stall);
    set_cpu(1'b1, 1'b0, 32'h4, 32'h0);
    run_cycle(); stalls += int'(obs_stall);
    chk32("t1_lw_rdata", obs_rdata, 32'd40);
    chk32("t1_stalls", 32'(stalls), 32'd0);
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);

    // DMA with an idle CPU: write 0x55 to address 8, then read it back
    set_dma(1'b1, 1'b1, 32'h8, 32'h55);
    run_cycle();
    chk1("t2_no_ack_on_rise", obs_ack, 1'b0);
    run_cycle();
    chk1("t2_wr_ack", obs_ack, 1'b1);
    set_dma(1'b1, 1'b0, 32'h8, 32'h0);
    run_cycle();
    chk1("t2_rd_ack", obs_ack, 1'b1);
    set_dma(1'b0, 1'b0, 32'h0, 32'h0);
    run_cycle();
    chk1("t2_rvalid", obs_rvalid, 1'b1);
    chk32("t2_rdata", obs_dma_rdata, 32'h55);
    chk1("t2_stall", obs_stall, 1'b0);
    run_cycle();

    // Starvation: CPU busy every cycle, DMA held high until acked
    set_cpu(1'b1, 1'b0, 32'h0, 32'h0);
    set_dma(1'b1, 1'b1, 32'h20, 32'hA5);
    first = -1;
    for (int i = 1; i <= 10; i++) begin
      run_cycle();
      if (obs_ack && first < 0) first = i;
      if (e_ack) set_dma(1'b0, 1'b0, 32'h0, 32'h0);
    end
    chk32("t3_first_ack_cycle", 32'(first), 32'(SLIM + 1));

    // Burst cap: ten DMA writes against a continuously busy CPU
    k = 0; run = 0; maxrun = 0; acks = 0;
    for (int i = 0; i < 100 && k < 10; i++) begin
      set_dma(1'b1, 1'b1, 32'h40 + 32'(k) * 4, 32'h100 + 32'(k));
      run_cycle();
      if (obs_ack) begin
        acks++; run++;
        if (run > maxrun) maxrun = run;
      end else begin
        run = 0;
      end
      if (e_ack) k++;
    end
    set_dma(1'b0, 1'b0, 32'h0, 32'h0);
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    run_cycle();
    run_cycle();
    chk32("t4_accesses", 32'(k), 32'd10);
    chk32("t4_acks", 32'(acks), 32'd10);
    chk32("t4_max_run", 32'(maxrun), 32'(MBUR));
    for (int i = 0; i < 10; i++) chk32("t4_mem", tb_mem[16 + i], 32'h100 + 32'(i));

    // Handover: CPU lw stalled behind a DMA write to the same address
    set_dma(1'b1, 1'b1, 32'h4, 32'd99);
    run_cycle();
    set_cpu(1'b1, 1'b0, 32'h4, 32'h0);
    run_cycle();
    chk1("t5_dma_ack", obs_ack, 1'b1);
    chk1("t5_stall_b", obs_stall, 1'b1);
    set_dma(1'b0, 1'b0, 32'h0, 32'h0);
    run_cycle();
    chk1("t5_stall_c", obs_stall, 1'b1);
    run_cycle();
    chk1("t5_stall_d", obs_stall, 1'b0);
    chk32("t5_lw_rdata", obs_rdata, 32'd99);
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    run_cycle();

    // Reset mid-burst with a read return in flight
    set_dma(1'b1, 1'b0, 32'h8, 32'h0);
    run_cycle();
    run_cycle();
    set_dma(1'b1, 1'b1, 32'h30, 32'h7);
    set_cpu(1'b1, 1'b0, 32'h8, 32'h0);
    RESET = 1'b1;
    #1;
    chk1("t6_cpu_stall", cpu_stall, 1'b0);
    chk1("t6_dma_ack", dma_ack, 1'b0);
    chk1("t6_mem_write", mem_write, 1'b0);
    chk1("t6_dma_rvalid", dma_rvalid, 1'b0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    model_reset();
    set_dma(1'b0, 1'b0, 32'h0, 32'h0);
    run_cycle();
    chk1("t6_lw_stall", obs_stall, 1'b0);
    chk32("t6_lw_rdata", obs_rdata, 32'h55);

    // Random traffic; both sides hold a request until it is performed
    for (int i = 0; i < 400; i++) begin
      if (!e_stall) begin
        case ($urandom_range(0, 2))
          0: set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
          1: set_cpu(1'b1, 1'b0, 32'($urandom_range(0, 15)) << 2, 32'h0);
          default: set_cpu(1'b0, 1'b1, 32'($urandom_range(0, 15)) << 2, $urandom);
        endcase
      end
      if (!dma_req || e_ack) begin
        if ($urandom_range(0, 9) < 6)
          set_dma(1'b1, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom);
        else
          set_dma(1'b0, 1'b0, 32'h0, 32'h0);
      end
      run_cycle();
    end
    set_cpu(1'b0, 1'b0, 32'h0, 32'h0);
    set_dma(1'b0, 1'b0, 32'h0, 32'h0);
    run_cycle();
    run_cycle();
    for (int i = 0; i < 16; i++) chk32("rand_mem", tb_mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
